// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and state type for the interrupt priority controller
//
// Purpose : source count, id width and grant FSM state encoding used by
//           irq_priority_ctrl and prio_enc_8.
// Ports   : none (package).
package irq_pkg;

  localparam int N_IRQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc_8.sv
// rtl/prio_enc_8.sv - 8-input fixed-priority encoder, highest index wins
//
// Purpose : combinational selector returning the binary index of the
//           highest set request bit.
// Ports   : i_req [7:0]  request vector
//           o_id  [2:0]  index of highest set bit (0 when none set)
//           o_any        at least one request bit set
module prio_enc_8
  import irq_pkg::*;
(
  input  logic [N_IRQ-1:0] i_req,
  output logic [ID_W-1:0]  o_id,
  output logic             o_any
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    o_id  = '0;
    o_any = |i_req;
    for (int i = 0; i < N_IRQ; i++) begin
      if (i_req[i]) begin
        o_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// rtl/irq_priority_ctrl.sv - 8-source interrupt capture and fixed-priority grant controller
//
// Purpose : captures request events (edge or level), holds them as pending,
//           grants the highest unmasked pending source through a
//           valid/ready handshake, and flags requests that arrive while
//           their source is already pending.
// Ports   : clk              clock, rising edge
//           rst              asynchronous active-high reset
//           irq_in    [7:0]  raw request lines, 7 = highest priority
//           mask      [7:0]  1 blocks selection, not capture
//           out_ready        downstream accepts out_id
//           clr_lost         pulse clearing the lost flags
//           out_valid        out_id carries a granted source
//           out_id    [2:0]  granted source index
//           pending   [7:0]  captured, not-yet-granted requests
//           lost      [7:0]  sticky per-source overrun flags
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] mask,
  input  logic             out_ready,
  input  logic             clr_lost,
  output logic             out_valid,
  output logic [ID_W-1:0]  out_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] lost
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_IRQ-1:0]  r_irq_q;
  logic [N_IRQ-1:0]  r_pending;
  logic [N_IRQ-1:0]  r_lost;
  logic [ID_W-1:0]   r_out_id;

  logic [N_IRQ-1:0]  w_evt;
  logic [N_IRQ-1:0]  w_eligible;
  logic [N_IRQ-1:0]  w_clr;
  logic [N_IRQ-1:0]  w_lost_set;
  logic [ID_W-1:0]   w_sel_id;
  logic              w_sel_any;
  logic              w_load;
  logic              w_grant;

  assign w_evt      = EDGE_MODE ? (irq_in & ~r_irq_q) : irq_in;
  assign w_eligible = r_pending & ~mask;

  prio_enc_8 u_prio_enc (
    .i_req (w_eligible),
    .o_id  (w_sel_id),
    .o_any (w_sel_any)
  );

  // A new id may be loaded whenever the output slot is empty or being
  // consumed this cycle; this gives one grant per cycle under out_ready=1.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_load      = (r_state == IDLE) || out_ready;
    if (w_load) begin
      if (w_sel_any) begin
        w_state_nxt = HOLD;
        w_grant     = 1'b1;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  assign w_clr = w_grant ? (N_IRQ'(1) << w_sel_id) : '0;

  // A loss is only an event landing on a bit that stays pending; if the
  // same bit is being granted this cycle the event simply re-arms it.
  assign w_lost_set = w_evt & r_pending & ~w_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_q   <= '0;
      r_pending <= '0;
      r_lost    <= '0;
      r_out_id  <= '0;
    end else begin
      r_irq_q   <= irq_in;
      // Set after clear: a same-cycle event survives the grant.
      r_pending <= (r_pending & ~w_clr) | w_evt;
      r_lost    <= (clr_lost ? '0 : r_lost) | w_lost_set;
      if (w_grant) begin
        r_out_id <= w_sel_id;
      end
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_id    = r_out_id;
  assign pending   = r_pending;
  assign lost      = r_lost;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb/tb_irq_priority_ctrl.sv - directed self-checking bench for irq_priority_ctrl
module tb_irq_priority_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       out_ready;
  logic       clr_lost;
  logic       out_valid;
  logic [2:0] out_id;
  logic [7:0] pending;
  logic [7:0] lost;

  logic [7:0] irq_l;
  logic       out_valid_l;
  logic [2:0] out_id_l;
  logic [7:0] pending_l;
  logic [7:0] lost_l;

  int checks;
  int failures;

  irq_priority_ctrl #(.EDGE_MODE(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask      (mask),
    .out_ready (out_ready),
    .clr_lost  (clr_lost),
    .out_valid (out_valid),
    .out_id    (out_id),
    .pending   (pending),
    .lost      (lost)
  );

  irq_priority_ctrl #(.EDGE_MODE(1'b0)) u_dut_lvl (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_l),
    .mask      (8'h00),
    .out_ready (1'b1),
    .clr_lost  (1'b0),
    .out_valid (out_valid_l),
    .out_id    (out_id_l),
    .pending   (pending_l),
    .lost      (lost_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    irq_in    = 8'h00;
    irq_l     = 8'h00;
    mask      = 8'h00;
    out_ready = 1'b0;
    clr_lost  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_valid",   {7'd0, out_valid}, 8'h00);
    chk("rst_id",      {5'd0, out_id},    8'h00);
    chk("rst_pending", pending,           8'h00);
    chk("rst_lost",    lost,              8'h00);
    rst = 1'b0;

    // Single pulse, two-edge latency, then back to idle
    out_ready = 1'b1;
    irq_in    = 8'h04;
    tick();
    irq_in = 8'h00;
    chk("lat_pend_cap", pending,           8'h04);
    chk("lat_valid_n1", {7'd0, out_valid}, 8'h00);
    tick();
    chk("lat_valid_n2", {7'd0, out_valid}, 8'h01);
    chk("lat_id",       {5'd0, out_id},    8'h02);
    chk("lat_pend_clr", pending,           8'h00);
    tick();
    chk("lat_idle",     {7'd0, out_valid}, 8'h00);
    chk("lat_pend_end", pending,           8'h00);

    // Three sources at once, stalled then drained one per cycle
    out_ready = 1'b0;
    irq_in    = 8'hA1;
    tick();
    irq_in = 8'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", {7'd0, out_valid}, 8'h01);
      chk("stall_id",    {5'd0, out_id},    8'h07);
    end
    chk("stall_pend", pending, 8'h21);
    out_ready = 1'b1;
    tick();
    chk("drain_id5",  {5'd0, out_id},    8'h05);
    chk("drain_v5",   {7'd0, out_valid}, 8'h01);
    tick();
    chk("drain_id0",  {5'd0, out_id},    8'h00);
    chk("drain_v0",   {7'd0, out_valid}, 8'h01);
    tick();
    chk("drain_idle", {7'd0, out_valid}, 8'h00);
    chk("drain_pend", pending,           8'h00);

    // Fully masked source is retained, granted once unmasked
    mask   = 8'hFF;
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    chk("mask_valid", {7'd0, out_valid}, 8'h00);
    chk("mask_pend",  pending,           8'h08);
    chk("mask_id",    {5'd0, out_id},    8'h00);
    mask = 8'h00;
    tick();
    chk("unmask_valid", {7'd0, out_valid}, 8'h01);
    chk("unmask_id",    {5'd0, out_id},    8'h03);
    chk("unmask_pend",  pending,           8'h00);
    tick();
    chk("unmask_idle",  {7'd0, out_valid}, 8'h00);

    // Overrun on source 4 while its grant is stalled
    out_ready = 1'b0;
    irq_in    = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    chk("lost_grant", {5'd0, out_id}, 8'h04);
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    chk("lost_none", lost, 8'h00);
    tick();
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    chk("lost_set",      lost,              8'h10);
    chk("lost_pend",     pending,           8'h10);
    chk("lost_hold_id",  {5'd0, out_id},    8'h04);
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk("lost_clr", lost, 8'h00);
    irq_in   = 8'h10;
    clr_lost = 1'b1;
    tick();
    irq_in = 8'h00;
    chk("lost_set_wins", lost, 8'h10);
    tick();
    clr_lost = 1'b0;
    chk("lost_clr2", lost, 8'h00);

    // Asynchronous reset mid-grant with pending 0x60
    out_ready = 1'b1;
    tick();
    chk("pre_rst_id", {5'd0, out_id}, 8'h04);
    out_ready = 1'b0;
    irq_in    = 8'h60;
    tick();
    irq_in = 8'h00;
    chk("pre_rst_valid", {7'd0, out_valid}, 8'h01);
    chk("pre_rst_pend",  pending,           8'h60);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {7'd0, out_valid}, 8'h00);
    chk("arst_id",    {5'd0, out_id},    8'h00);
    chk("arst_pend",  pending,           8'h00);
    chk("arst_lost",  lost,              8'h00);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", {7'd0, out_valid}, 8'h00);
    chk("post_rst_pend",  pending,           8'h00);

    // Level mode: held request regranted every cycle
    irq_l = 8'h02;
    tick();
    chk("lvl_pend",  pending_l,           8'h02);
    chk("lvl_v0",    {7'd0, out_valid_l}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lvl_valid", {7'd0, out_valid_l}, 8'h01);
      chk("lvl_id",    {5'd0, out_id_l},    8'h01);
      chk("lvl_pend2", pending_l,           8'h02);
    end
    chk("lvl_lost", lost_l, 8'h00);
    irq_l = 8'h00;
    tick();
    tick();
    chk("lvl_idle", {7'd0, out_valid_l}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_priority_ctrl.md
IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

Interface
REQ-001 Parameter: EDGE_MODE, 1, 1 = capture rising edges of irq_in; 0 = capture while irq_in is high (level).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 irq_in  input  8  raw request lines, one per source, index 7 = highest priority.
REQ-005 mask  input  8  per-source mask; 1 blocks selection but not capture.
REQ-006 out_ready  input  1  downstream accepts out_id when high with out_valid.
REQ-007 clr_lost  input  1  single-cycle pulse that clears lost.
REQ-008 out_valid  output  1  out_id holds a granted source number.
REQ-009 out_id  output  3  binary index of granted source.
REQ-010 pending  output  8  captured, not-yet-granted requests.
REQ-011 lost  output  8  sticky flag per source; a request arrived while that bit was already pending.

Function
REQ-012 Capture SHALL use a registered copy irq_q of irq_in (reset 0). Per source i, evt[i] = irq_in[i] & ~irq_q[i] when EDGE_MODE=1, and evt[i] = irq_in[i] when EDGE_MODE=0.
REQ-013 pending[i] SHALL be set on the clock edge after evt[i].
REQ-014 Eligible set = pending & ~mask. Selection SHALL be fixed priority, highest index wins.
REQ-015 The FSM SHALL have two states:
- IDLE: out_valid=0.
- HOLD: out_valid=1.
REQ-016 IDLE->HOLD when eligible is non-zero; on that edge, out_id SHALL take the selected index and that pending bit SHALL clear.
REQ-017 In HOLD with out_ready=0, out_valid and out_id SHALL stay stable regardless of irq_in, mask or pending changes.
REQ-018 In HOLD with out_ready=1, the block SHALL load the next eligible index the same cycle: it stays in HOLD and clears that bit, or goes to IDLE if none is eligible. Back-to-back grants SHALL therefore occur at one per cycle.
REQ-019 Latency: an edge on irq_in sampled at cycle n SHALL give out_valid=1 at cycle n+2 when the block is idle and unmasked.
REQ-020 If a bit is cleared by a grant and its evt arrives in the same cycle, pending SHALL remain 1 (set wins; no request dropped).
REQ-021 If evt[i] arrives while pending[i]=1 and no clear occurs that cycle, lost[i] SHALL set. When clr_lost and a new loss coincide, set wins.
REQ-022 A masked pending bit SHALL be retained. Unmasking it SHALL make it selectable the next cycle.
REQ-023 All-masked or all-zero eligible SHALL leave the block in IDLE with out_id unchanged.

Reset
REQ-024 On rst high, irq_q, pending, lost, out_valid and out_id SHALL be 0 and the state SHALL be IDLE, asynchronously. This applies mid-grant and discards any in-flight id.
REQ-025 Edges present at the first clock after reset release SHALL be detected relative to irq_q=0.

Structure
REQ-026 A shared package irq_pkg SHALL hold N_IRQ=8, ID_W=3 and the state enum {IDLE, HOLD}.
REQ-027 The combinational highest-index selector SHALL be a sub-module prio_enc_8 (8-bit in, 3-bit id plus any-valid out), instantiated once.

Verification
REQ-028 Reset, then pulse irq_in=8'b0000_0100 for one cycle with out_ready=1 -> out_valid=1, out_id=2 two cycles after the sample, then out_valid=0 the next cycle, pending=0.
REQ-029 Raise irq_in=8'b1010_0001 in one cycle with out_ready held 0 for 5 cycles, then 1 -> out_id=7 stable for all 5 cycles, then grants 5 and 0 on consecutive cycles, then IDLE.
REQ-030 mask=8'hFF, pulse irq_in bit 3 -> out_valid stays 0 and pending=8'h08; set mask=0 -> out_id=3 the next cycle.
REQ-031 Pulse bit 4 twice while grant is stalled by out_ready=0 -> lost=8'h10; pulse clr_lost -> lost=0.
REQ-032 Assert rst while out_valid=1 and pending=8'h60 -> all outputs 0 immediately; no grant after release without new edges.
REQ-033 EDGE_MODE=0, hold irq_in bit 1 high with out_ready=1 -> out_id=1 is regranted every cycle.
